branch_unit: RTL

- Branch execution unit: the producer side of the result-broadcast bus that the instruction fetch unit snoops for `bcast_rs_i == BU` redirects.
- Accepts one dispatched RV32 conditional branch at a time and collects its two operands, either at issue or by snooping the broadcast bus.
- Evaluates the condition and broadcasts the next PC with source tag BU. Fetch stalls on every branch, so every accepted branch produces exactly one broadcast, taken or not.

---
 rtl/types.sv | 44 ++++
 rtl/branch_compare.sv | 46 ++++
 rtl/branch_unit.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/types.sv
// ============================================================================
// Module : types (package)
// Shared enums, opcode constant and B-immediate helper for the branch unit.
// Revision: 1.0
// ============================================================================
`default_nettype none

package types;

    typedef enum logic [2:0] {
        NONE = 3'd0,
        ALU  = 3'd1,
        MUL  = 3'd2,
        LSU  = 3'd3,
        BU   = 3'd4
    } e_functional_unit;

    typedef enum logic [2:0] {
        BEQ  = 3'b000,
        BNE  = 3'b001,
        BLT  = 3'b100,
        BGE  = 3'b101,
        BLTU = 3'b110,
        BGEU = 3'b111
    } e_branch_funct3;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_OPS = 2'd1,
        EXEC     = 2'd2,
        BCAST    = 2'd3
    } e_bu_state;

    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
    localparam int         B_IMM_WIDTH   = 13;

    // Raw 13-bit B-type offset; callers sign-extend to their own width.
    function automatic logic [B_IMM_WIDTH-1:0] b_imm(input logic [31:0] insn);
        return {insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
    endfunction

endpackage

`default_nettype wire

// File: rtl/branch_compare.sv
// ============================================================================
// Module : branch_compare
// Combinational RV32 branch condition evaluation and next-PC selection.
// Revision: 1.0
// ============================================================================
`default_nettype none

module branch_compare
    import types::*;
#(
    parameter int ADDRESS_WIDTH = 64
) (
    input  logic [2:0]               funct3,
    input  logic [ADDRESS_WIDTH-1:0] rs1,
    input  logic [ADDRESS_WIDTH-1:0] rs2,
    input  logic [ADDRESS_WIDTH-1:0] pc,
    input  logic [ADDRESS_WIDTH-1:0] imm,
    output logic                     taken,
    output logic [ADDRESS_WIDTH-1:0] next_pc
);

    logic lt_signed;
    logic lt_unsigned;

    assign lt_signed   = $signed(rs1) < $signed(rs2);
    assign lt_unsigned = rs1 < rs2;

    always_comb begin
        taken = 1'b0;
        case (funct3)
            BEQ:     taken = (rs1 == rs2);
            BNE:     taken = (rs1 != rs2);
            BLT:     taken = lt_signed;
            BGE:     taken = !lt_signed;
            BLTU:    taken = lt_unsigned;
            BGEU:    taken = !lt_unsigned;
            default: taken = 1'b0;
        endcase
    end

    // Both targets wrap modulo 2^ADDRESS_WIDTH.
    assign next_pc = taken ? (pc + imm) : (pc + ADDRESS_WIDTH'(4));

endmodule

`default_nettype wire

// File: rtl/branch_unit.sv
// ============================================================================
// Module : branch_unit
// Branch execution unit: collects operands, evaluates, broadcasts next PC.
// Revision: 1.0
// ============================================================================
`default_nettype none

module branch_unit
    import types::*;
#(
    parameter int ADDRESS_WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,

    input  logic                     issue_valid_i,
    output logic                     issue_ready_o,
    input  logic [31:0]              issue_insn_i,
    input  logic [ADDRESS_WIDTH-1:0] issue_pc_i,
    input  logic                     issue_rs1_valid_i,
    input  logic [ADDRESS_WIDTH-1:0] issue_rs1_value_i,
    input  e_functional_unit         issue_rs1_tag_i,
    input  logic                     issue_rs2_valid_i,
    input  logic [ADDRESS_WIDTH-1:0] issue_rs2_value_i,
    input  e_functional_unit         issue_rs2_tag_i,

    input  logic                     bcast_valid_i,
    input  logic [ADDRESS_WIDTH-1:0] bcast_value_i,
    input  e_functional_unit         bcast_rs_i,

    output logic                     bcast_req_o,
    input  logic                     bcast_gnt_i,
    output logic [ADDRESS_WIDTH-1:0] bcast_value_o,
    output e_functional_unit         bcast_rs_o,
    output logic                     taken_o
);

    e_bu_state state;
    e_bu_state next_state;

    logic [2:0]               funct3_q;
    logic [B_IMM_WIDTH-1:0]   imm_q;
    logic [ADDRESS_WIDTH-1:0] pc_q;
    logic [ADDRESS_WIDTH-1:0] rs1_val;
    logic [ADDRESS_WIDTH-1:0] rs2_val;
    logic                     rs1_rdy;
    logic                     rs2_rdy;
    e_functional_unit         rs1_tag;
    e_functional_unit         rs2_tag;

    logic                     issue_fire;
    logic                     bcast_usable;
    logic                     rs1_hit_issue;
    logic                     rs2_hit_issue;
    logic                     rs1_res_issue;
    logic                     rs2_res_issue;
    logic                     rs1_hit_wait;
    logic                     rs2_hit_wait;
    logic [ADDRESS_WIDTH-1:0] imm_ext;
    logic                     cmp_taken;
    logic [ADDRESS_WIDTH-1:0] cmp_next_pc;
    logic                     unused_insn_bits;

    // Opcode and register-index fields are not needed once dispatched.
    assign unused_insn_bits = ^{issue_insn_i[24:15], issue_insn_i[6:0]};

    assign issue_fire = issue_valid_i && issue_ready_o;

    // Own-tag broadcasts never carry a register value.
    assign bcast_usable  = bcast_valid_i && (bcast_rs_i != BU);
    assign rs1_hit_issue = bcast_usable && (bcast_rs_i == issue_rs1_tag_i);
    assign rs2_hit_issue = bcast_usable && (bcast_rs_i == issue_rs2_tag_i);
    assign rs1_res_issue = issue_rs1_valid_i || rs1_hit_issue;
    assign rs2_res_issue = issue_rs2_valid_i || rs2_hit_issue;
    assign rs1_hit_wait  = !rs1_rdy && bcast_usable && (bcast_rs_i == rs1_tag);
    assign rs2_hit_wait  = !rs2_rdy && bcast_usable && (bcast_rs_i == rs2_tag);

    assign imm_ext    = {{(ADDRESS_WIDTH-B_IMM_WIDTH){imm_q[B_IMM_WIDTH-1]}}, imm_q};
    assign bcast_rs_o = BU;

    branch_compare #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH)
    ) u_compare (
        .funct3  (funct3_q),
        .rs1     (rs1_val),
        .rs2     (rs2_val),
        .pc      (pc_q),
        .imm     (imm_ext),
        .taken   (cmp_taken),
        .next_pc (cmp_next_pc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            issue_ready_o <= 1'b0;
        end else begin
            state         <= next_state;
            issue_ready_o <= (next_state == IDLE);
        end
    end

    always_comb begin
        next_state  = state;
        bcast_req_o = 1'b0;
        case (state)
            IDLE: begin
                if (issue_fire) begin
                    next_state = (rs1_res_issue && rs2_res_issue) ? EXEC : WAIT_OPS;
                end
            end
            WAIT_OPS: begin
                if ((rs1_rdy || rs1_hit_wait) && (rs2_rdy || rs2_hit_wait)) begin
                    next_state = EXEC;
                end
            end
            EXEC: begin
                next_state = BCAST;
            end
            BCAST: begin
                bcast_req_o = 1'b1;
                if (bcast_gnt_i) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            funct3_q <= '0;
            imm_q    <= '0;
            pc_q     <= '0;
            rs1_val  <= '0;
            rs2_val  <= '0;
            rs1_rdy  <= 1'b0;
            rs2_rdy  <= 1'b0;
            rs1_tag  <= NONE;
            rs2_tag  <= NONE;
        end else if (state == IDLE) begin
            if (issue_fire) begin
                funct3_q <= issue_insn_i[14:12];
                imm_q    <= b_imm(issue_insn_i);
                pc_q     <= issue_pc_i;
                rs1_tag  <= issue_rs1_tag_i;
                rs2_tag  <= issue_rs2_tag_i;
                rs1_rdy  <= rs1_res_issue;
                rs2_rdy  <= rs2_res_issue;
                rs1_val  <= issue_rs1_valid_i ? issue_rs1_value_i : bcast_value_i;
                rs2_val  <= issue_rs2_valid_i ? issue_rs2_value_i : bcast_value_i;
            end
        end else if (state == WAIT_OPS) begin
            if (rs1_hit_wait) begin
                rs1_val <= bcast_value_i;
                rs1_rdy <= 1'b1;
            end
            if (rs2_hit_wait) begin
                rs2_val <= bcast_value_i;
                rs2_rdy <= 1'b1;
            end
        end
    end

    // Result registers only move in EXEC, so they stay frozen through BCAST.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            taken_o       <= 1'b0;
            bcast_value_o <= '0;
        end else if (state == EXEC) begin
            taken_o       <= cmp_taken;
            bcast_value_o <= cmp_next_pc;
        end
    end

endmodule

`default_nettype wire
